// File: rtl/caesar_decipher_stream.sv
// Streaming Caesar decipher: applies the inverse of an encryption-side key to a byte
// stream and buffers the plaintext in a small FIFO ahead of a valid/ready output.
module caesar_decipher_stream #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic             key_shift_dir,
  input  logic [4:0]       key_shift_num,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             err_invalid_key_shift_num,
  output logic             busy,
  output logic [CNT_W-1:0] char_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    KEY_WAIT = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               key_dir_q, key_dir_d;
  logic [4:0]         key_num_q, key_num_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   char_count_q, char_count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [7:0]         mem_char_q [FIFO_DEPTH];
  logic [7:0]         mem_char_d [FIFO_DEPTH];
  logic               mem_last_q [FIFO_DEPTH];
  logic               mem_last_d [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic key_ok;
  logic key_accept;
  logic head_last;

  function automatic logic [7:0] decipher(input logic [7:0] c, input logic dir,
                                          input logic [4:0] n);
    logic [7:0] base;
    logic [5:0] o;
    logic [5:0] r;
    logic       is_letter;
    base      = 8'h00;
    is_letter = 1'b0;
    if (c >= 8'h41 && c <= 8'h5A) begin
      base      = 8'h41;
      is_letter = 1'b1;
    end else if (c >= 8'h61 && c <= 8'h7A) begin
      base      = 8'h61;
      is_letter = 1'b1;
    end
    o = 6'(c - base);
    // Encryption shifted right by n, so undo it by adding 26-n; left shifts undo by adding n.
    if (dir) r = o + {1'b0, n};
    else     r = o + 6'd26 - {1'b0, n};
    if (r >= 6'd26) r = r - 6'd26;
    return is_letter ? (base + {2'b00, r}) : c;
  endfunction

  // Valid/ready: a byte moves on a channel only in a cycle where valid and ready are both
  // high at the rising edge; valid never waits on ready, and ready here never looks at valid.
  always_comb begin
    fifo_empty = (fifo_cnt_q == '0);
    fifo_full  = (fifo_cnt_q == DEPTH_C);
    in_ready   = (state_q == RUN) && !fifo_full;
    out_valid  = !fifo_empty;
    out_char   = fifo_empty ? 8'h00 : mem_char_q[rd_ptr_q];
    head_last  = mem_last_q[rd_ptr_q];
    out_last   = !fifo_empty && head_last;
    push       = in_valid && in_ready;
    pop        = out_valid && out_ready;
    key_ok     = (key_shift_num <= 5'd26);
    key_accept = key_load &&
                 ((state_q == KEY_WAIT) || ((state_q == RUN) && fifo_empty && !push));
    busy       = !fifo_empty || (state_q == DRAIN);
    err_invalid_key_shift_num = err_q;
    char_count = char_count_q;
  end

  always_comb begin
    state_d      = state_q;
    key_dir_d    = key_dir_q;
    key_num_d    = key_num_q;
    err_d        = err_q;
    char_count_d = char_count_q;

    if (push && (char_count_q != '1)) char_count_d = char_count_q + 1'b1;

    case (state_q)
      KEY_WAIT, RUN: begin
        if (key_accept) begin
          if (key_ok) begin
            key_dir_d    = key_shift_dir;
            key_num_d    = key_shift_num;
            err_d        = 1'b0;
            char_count_d = '0;
            state_d      = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = KEY_WAIT;
          end
        end else if ((state_q == RUN) && push && in_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) state_d = RUN;
      end
      default: state_d = KEY_WAIT;
    endcase
  end

  always_comb begin
    mem_char_d = mem_char_q;
    mem_last_d = mem_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      mem_char_d[wr_ptr_q] = decipher(in_char, key_dir_q, key_num_q);
      mem_last_d[wr_ptr_q] = in_last;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (pop && !push) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= KEY_WAIT;
      key_dir_q    <= 1'b0;
      key_num_q    <= 5'd0;
      err_q        <= 1'b0;
      char_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_char_q[i] <= 8'h00;
        mem_last_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      key_dir_q    <= key_dir_d;
      key_num_q    <= key_num_d;
      err_q        <= err_d;
      char_count_q <= char_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      mem_char_q   <= mem_char_d;
      mem_last_q   <= mem_last_d;
    end
  end

endmodule

// File: doc/caesar_decipher_stream.md
Name: caesar_decipher_stream

Overview:
Streaming Caesar decipher. It is the receive-side counterpart of caesar_cipher.
- The key is loaded in encryption terms (direction and shift that produced the ciphertext). The block applies the inverse shift.
- Ciphertext bytes arrive on a valid/ready input, are deciphered and buffered in a small FIFO, and leave on a valid/ready output.
- Non-letters pass through unchanged, matching the file-encryption flow.

Parameters:
- FIFO_DEPTH, 4, output buffer entries; power of two, ≥2.
- CNT_W, 16, width of the accepted-character counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_load  in  1  strobe: capture key_shift_dir/key_shift_num.
- key_shift_dir  in  1  encryption direction of key: 0 = right (decipher subtracts), 1 = left (decipher adds).
- key_shift_num  in  5  encryption shift, legal 0..26.
- in_valid  in  1  ciphertext byte valid.
- in_ready  out  1  block can accept a byte.
- in_char  in  8  ciphertext byte.
- in_last  in  1  byte is the last of the message.
- out_valid  out  1  plaintext byte valid.
- out_ready  in  1  sink accepts the byte.
- out_char  out  8  deciphered byte.
- out_last  out  1  byte is the last of the message.
- err_invalid_key_shift_num  out  1  last key_load had shift > 26.
- busy  out  1  FIFO non-empty or state DRAIN.
- char_count  out  CNT_W  bytes accepted since last accepted key_load; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - state KEY_WAIT, FIFO emptied, key cleared.
  - in_ready=0, out_valid=0, out_char=8'h00, out_last=0, err=0, busy=0, char_count=0.
  - Reset mid-stream discards all buffered data; a new key_load is required.
- States: KEY_WAIT, RUN, DRAIN.
- KEY_WAIT: in_ready=0.
  - key_load with key_shift_num ≤ 26: capture key, set err=0, clear char_count, go to RUN.
  - key_load with key_shift_num > 26: set err=1, stay in KEY_WAIT.
- RUN: in_ready = (FIFO count < FIFO_DEPTH).
  - No same-cycle pass-through when full: in_ready is 0 even if out_ready=1.
  - A handshake (in_valid & in_ready) writes the deciphered byte plus in_last into the FIFO and increments char_count.
  - A handshake with in_last=1 moves the state to DRAIN.
  - key_load in RUN is accepted only when the FIFO is empty and no input handshake occurs that cycle; it behaves as in KEY_WAIT. An invalid key sends the state to KEY_WAIT. Any other key_load is ignored.
- DRAIN: in_ready=0; key_load is ignored.
  - On the output handshake of the entry with out_last=1, return to RUN with the key retained.
- Output and latency:
  - out_valid = FIFO non-empty; out_char/out_last come from the FIFO head.
  - A byte accepted at edge t is visible at the output after edge t (one-cycle latency) when the FIFO was empty.
  - Ordering is strict FIFO. Head data is held stable while out_valid & !out_ready.
  - Simultaneous push and pop when not full leaves the count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Decipher arithmetic (combinational at FIFO write):
  - Uppercase (0x41..0x5A): o = c − 0x41, base = 0x41. Lowercase (0x61..0x7A): o = c − 0x61, base = 0x61.
  - dir=0: r = o + 26 − N. dir=1: r = o + N. Both use 6-bit arithmetic, range 0..51.
  - If r ≥ 26 then r −= 26. Output = base + r.
  - N=0 and N=26 are identity.
  - Any other byte (including 0x00 and 0x80..0xFF) is passed through unchanged.

Test Plan:
- Key dir=0, N=1; send "B","A","a","z" → out "A","Z","z","y"; char_count=4, err=0.
- Key dir=1, N=5; send "V","v","E" → "A","a","J". Send 0x21, 0x7B, 0x00, 0xFF → same bytes out unchanged.
- key_load N=27 → err=1, state KEY_WAIT, in_ready=0. Then key_load N=26 → err=0, in_ready=1, "Q"→"Q".
- Backpressure, FIFO_DEPTH=4: out_ready=0, offer 6 bytes → in_ready drops after the 4th accepted. Raise out_ready → all 6 bytes out in order, head held stable while stalled.
- in_last on the 3rd byte → in_ready=0 until out_last handshake; key_load during DRAIN ignored; then state RUN with the same key.
- Round-trip and reset:
  - Encrypt "A".."Z","a".."z" with caesar_cipher (dir=0, N=2), feed to this block with the same key → output equals the original 52 letters.
  - Assert rst_n=0 mid-stream → outputs return to their reset values and char_count=0.
